// File: rtl/frontend_sequencer_if.sv
// rtl/frontend_sequencer_if.sv - frontend datapath control bundle driven by the layer sequencer
interface frontend_sequencer_if #(
    parameter int addr_width_ia       = 11,
    parameter int wts_bram_addr_width = 4,
    parameter int ram_address_width   = 5
);
    logic [wts_bram_addr_width-1:0] wts_bram_addr;
    logic                           enable_wts_rom;
    logic                           wts_rf_enable;
    logic                           addr_rf_enable;
    logic                           addr_bram_enable;
    logic [ram_address_width-1:0]   ram_address;
    logic                           enable_IA_ram;
    logic [addr_width_ia-1:0]       address_ia;
    logic [2:0]                     control_arbiter;
    logic [2:0]                     addr_arbiter_ctrl;
    logic                           product_valid;
    logic                           pool_enable;
    logic                           hold;
    logic                           pool_done;

    modport master (
        output wts_bram_addr, enable_wts_rom, wts_rf_enable, addr_rf_enable,
        output addr_bram_enable, ram_address, enable_IA_ram, address_ia,
        output control_arbiter, addr_arbiter_ctrl, product_valid, pool_enable,
        input  hold, pool_done
    );

    modport slave (
        input  wts_bram_addr, enable_wts_rom, wts_rf_enable, addr_rf_enable,
        input  addr_bram_enable, ram_address, enable_IA_ram, address_ia,
        input  control_arbiter, addr_arbiter_ctrl, product_valid, pool_enable,
        output hold, pool_done
    );
endinterface

// File: rtl/frontend_sequencer.sv
// rtl/frontend_sequencer.sv - layer sequencer for the convolution frontend (optional pool stage: FRONTEND_SEQ_POOL_EN)
module frontend_sequencer #(
    parameter int WTS_GROUPS          = 16,
    parameter int IA_BEATS            = 8,
    parameter int ARB_PHASES          = 8,
    parameter int MULT_LAT            = 2,
    parameter int addr_width_ia       = 11,
    parameter int wts_bram_addr_width = 4,
    parameter int ram_address_width   = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_width_ia-1:0] ia_base,
    output logic                     busy,
    output logic                     done,
    frontend_sequencer_if.master     dp
);
    localparam int BW  = (IA_BEATS > 1) ? $clog2(IA_BEATS) : 1;
    localparam int DW  = $clog2(MULT_LAT + 2);
    localparam int SRW = MULT_LAT + 1;
    localparam int GW  = wts_bram_addr_width;

`ifdef FRONTEND_SEQ_POOL_EN
    typedef enum logic [2:0] {IDLE, FETCH_W, LOAD_W, LOAD_A, STREAM, DRAIN, POOL, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH_W, LOAD_W, LOAD_A, STREAM, DRAIN, DONE} state_t;
`endif

    state_t                   state;
    logic [GW-1:0]            g;
    logic [GW-1:0]            g_next;
    logic [BW-1:0]            b;
    logic [2:0]               p;
    logic [DW-1:0]            dcnt;
    logic [addr_width_ia-1:0] ia_base_q;
    logic [SRW-1:0]           vld_sr;
    logic                     issue;

    // An issue is a STREAM cycle whose hold is low; it feeds the product-valid pipe.
    assign issue            = (state == STREAM) && !dp.hold;
    assign g_next           = g + GW'(1);
    assign dp.product_valid = vld_sr[MULT_LAT];

`ifndef FRONTEND_SEQ_POOL_EN
    logic unused_pool_done;
    assign unused_pool_done = dp.pool_done;
    assign dp.pool_enable   = 1'b0;
`endif

    // Layer FSM: outputs for a state are registered on the edge that enters it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            g                    <= '0;
            b                    <= '0;
            p                    <= '0;
            dcnt                 <= '0;
            ia_base_q            <= '0;
            vld_sr               <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            dp.wts_bram_addr     <= '0;
            dp.enable_wts_rom    <= 1'b0;
            dp.wts_rf_enable     <= 1'b0;
            dp.addr_rf_enable    <= 1'b0;
            dp.addr_bram_enable  <= 1'b0;
            dp.ram_address       <= '0;
            dp.enable_IA_ram     <= 1'b0;
            dp.address_ia        <= '0;
            dp.control_arbiter   <= '0;
            dp.addr_arbiter_ctrl <= '0;
`ifdef FRONTEND_SEQ_POOL_EN
            dp.pool_enable       <= 1'b0;
`endif
        end else begin
            dp.enable_wts_rom   <= 1'b0;
            dp.addr_bram_enable <= 1'b0;
            dp.wts_rf_enable    <= 1'b0;
            dp.addr_rf_enable   <= 1'b0;
            dp.enable_IA_ram    <= 1'b0;
            done                <= 1'b0;
            vld_sr              <= (vld_sr << 1) | SRW'(issue);

            case (state)
                IDLE: begin
                    if (start) begin
                        ia_base_q           <= ia_base;
                        g                   <= '0;
                        busy                <= 1'b1;
                        state               <= FETCH_W;
                        dp.enable_wts_rom   <= 1'b1;
                        dp.wts_bram_addr    <= '0;
                        dp.addr_bram_enable <= 1'b1;
                        dp.ram_address      <= '0;
                    end
                end
                FETCH_W: begin
                    // ROM word becomes valid one cycle after the fetch
                    dp.wts_rf_enable <= 1'b1;
                    state            <= LOAD_W;
                end
                LOAD_W: begin
                    dp.addr_rf_enable <= 1'b1;
                    state             <= LOAD_A;
                end
                LOAD_A: begin
                    b     <= '0;
                    p     <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (!dp.hold) begin
                        dp.enable_IA_ram     <= 1'b1;
                        dp.address_ia        <= ia_base_q
                                              + addr_width_ia'(g) * addr_width_ia'(IA_BEATS)
                                              + addr_width_ia'(b);
                        dp.control_arbiter   <= p;
                        dp.addr_arbiter_ctrl <= p;
                        if (p == 3'(ARB_PHASES - 1)) begin
                            p <= '0;
                            if (b == BW'(IA_BEATS - 1)) begin
                                dcnt  <= '0;
                                state <= DRAIN;
                            end else begin
                                b <= b + BW'(1);
                            end
                        end else begin
                            p <= p + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    // wait out the multiplier pipe so the last product is flagged
                    if (dcnt == DW'(MULT_LAT)) begin
                        if (g == GW'(WTS_GROUPS - 1)) begin
`ifdef FRONTEND_SEQ_POOL_EN
                            dp.pool_enable <= 1'b1;
                            state          <= POOL;
`else
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            g                   <= g_next;
                            state               <= FETCH_W;
                            dp.enable_wts_rom   <= 1'b1;
                            dp.wts_bram_addr    <= g_next;
                            dp.addr_bram_enable <= 1'b1;
                            dp.ram_address      <= ram_address_width'(g_next);
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
`ifdef FRONTEND_SEQ_POOL_EN
                POOL: begin
                    if (dp.pool_done) begin
                        dp.pool_enable <= 1'b0;
                        done           <= 1'b1;
                        state          <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frontend_sequencer.sv
// tb/tb_frontend_sequencer.sv - directed vector bench for frontend_sequencer
module tb_frontend_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] ia_base;
    logic        busy;
    logic        done;

    frontend_sequencer_if #(.addr_width_ia(11), .wts_bram_addr_width(4), .ram_address_width(5)) dp();

    frontend_sequencer #(
        .WTS_GROUPS(16), .IA_BEATS(8), .ARB_PHASES(8), .MULT_LAT(2),
        .addr_width_ia(11), .wts_bram_addr_width(4), .ram_address_width(5)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .ia_base (ia_base),
        .busy    (busy),
        .done    (done),
        .dp      (dp.master)
    );

    always #5 clock = ~clock;

`ifdef FRONTEND_SEQ_POOL_EN
    localparam int POOL_EXTRA = 11;
`else
    localparam int POOL_EXTRA = 0;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] outs;
    assign outs = 64'({busy, done, dp.wts_bram_addr, dp.enable_wts_rom, dp.wts_rf_enable,
                       dp.addr_rf_enable, dp.addr_bram_enable, dp.ram_address, dp.enable_IA_ram,
                       dp.address_ia, dp.control_arbiter, dp.addr_arbiter_ctrl,
                       dp.product_valid, dp.pool_enable});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // pool unit model: completes 10 cycles after pool_enable rises, plus a stray early pulse
    int  pe_cnt = 0;
    logic poke_pool = 1'b0;
    always @(negedge clock) begin
        pe_cnt    = dp.pool_enable ? pe_cnt + 1 : 0;
        dp.pool_done = poke_pool || (pe_cnt == 11);
    end

    typedef struct {
        logic [10:0] base;
        int          hs;
        int          hl;
        int          exp_done;
        int          exp_valid;
        int          exp_first_valid;
        logic [10:0] exp_first;
        logic [10:0] exp_g1;
        logic [10:0] exp_last;
    } vec_t;

    vec_t        tbl[4];
    logic [10:0] iss_addr[$];
    logic [2:0]  iss_p[$];
    logic [3:0]  wts_seq[$];
    int          done_cyc, n_valid, first_valid, pool_cnt, frozen_bad, arb_bad;
    logic        done_after, busy_after;

    task automatic run_layer(input logic [10:0] base, input int hs, input int hl);
        logic [10:0] held_addr;
        held_addr = '0;
        iss_addr.delete(); iss_p.delete(); wts_seq.delete();
        done_cyc = 0; n_valid = 0; first_valid = 0; pool_cnt = 0; frozen_bad = 0; arb_bad = 0;
        @(negedge clock);
        ia_base = base;
        start   = 1'b1;
        @(posedge clock);
        for (int n = 1; n <= 1400 && done_cyc == 0; n++) begin
            @(negedge clock);
            start = 1'b0;
            if (dp.enable_wts_rom) wts_seq.push_back(dp.wts_bram_addr);
            if (dp.enable_IA_ram) begin
                iss_addr.push_back(dp.address_ia);
                iss_p.push_back(dp.control_arbiter);
                if (dp.control_arbiter !== dp.addr_arbiter_ctrl) arb_bad++;
            end
            if (dp.product_valid) begin
                n_valid++;
                if (first_valid == 0) first_valid = n;
            end
            if (dp.pool_enable) pool_cnt++;
            if (done) done_cyc = n;
            if (n == hs) held_addr = dp.address_ia;
            if (hl > 0 && n > hs && n <= hs + hl && (dp.enable_IA_ram || dp.address_ia !== held_addr))
                frozen_bad++;
            dp.hold   = (n >= hs && n < hs + hl);
            poke_pool = (n == 100);
        end
        dp.hold   = 1'b0;
        poke_pool = 1'b0;
        @(negedge clock);
        done_after = done;
        busy_after = busy;
    endtask

    initial begin
        int idx, bad, seen_done;
        tbl[0] = '{11'd0,    0,  0, 1121, 1024, 7, 11'd0,    11'd8,   11'd127};
        tbl[1] = '{11'd2040, 0,  0, 1121, 1024, 7, 11'd2040, 11'd0,   11'd119};
        tbl[2] = '{11'd0,    20, 5, 1126, 1024, 7, 11'd0,    11'd8,   11'd127};
        tbl[3] = '{11'd100,  67, 1, 1122, 1024, 7, 11'd100,  11'd108, 11'd227};

        reset   = 1'b1;
        start   = 1'b1;
        ia_base = '0;
        dp.hold = 1'b0;
        #2 reset = 1'b0;

        // reset with start held high
        repeat (3) @(negedge clock);
        check("reset_outs", outs, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("busy_after_release", 64'(busy), 64'd1);
        check("fetch_after_release", 64'(dp.enable_wts_rom), 64'd1);
        start = 1'b0;
        reset = 1'b0;
        #1;
        check("async_reset_outs", outs, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // reset during group 3 stream
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        seen_done = 0;
        for (int n = 1; n <= 224; n++) begin
            @(negedge clock);
            start = 1'b0;
            if (done) seen_done++;
        end
        check("stream_before_abort", 64'(dp.enable_IA_ram), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_outs", outs, 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (done) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        // table-driven full layers
        for (int r = 0; r < 4; r++) begin
            run_layer(tbl[r].base, tbl[r].hs, tbl[r].hl);
            check($sformatf("done_cycle[%0d]", r), 64'(done_cyc), 64'(tbl[r].exp_done + POOL_EXTRA));
            check($sformatf("done_pulse[%0d]", r), 64'({done_after, busy_after}), 64'd0);
            check($sformatf("valid_count[%0d]", r), 64'(n_valid), 64'(tbl[r].exp_valid));
            check($sformatf("first_valid[%0d]", r), 64'(first_valid), 64'(tbl[r].exp_first_valid));
            check($sformatf("pool_cycles[%0d]", r), 64'(pool_cnt), 64'(POOL_EXTRA));
            check($sformatf("issue_count[%0d]", r), 64'(iss_addr.size()), 64'd1024);
            if (iss_addr.size() == 1024) begin
                check($sformatf("first_addr[%0d]", r), 64'(iss_addr[0]), 64'(tbl[r].exp_first));
                check($sformatf("g1_addr[%0d]", r), 64'(iss_addr[64]), 64'(tbl[r].exp_g1));
                check($sformatf("last_addr[%0d]", r), 64'(iss_addr[1023]), 64'(tbl[r].exp_last));
                bad = arb_bad;
                idx = 0;
                for (int g = 0; g < 16; g++)
                    for (int b = 0; b < 8; b++)
                        for (int p = 0; p < 8; p++) begin
                            logic [10:0] ea;
                            ea = 11'(tbl[r].base + 11'(g * 8 + b));
                            if (iss_addr[idx] !== ea || iss_p[idx] !== 3'(p)) bad++;
                            idx++;
                        end
                check($sformatf("issue_seq_bad[%0d]", r), 64'(bad), 64'd0);
            end
            bad = (wts_seq.size() == 16) ? 0 : 1;
            foreach (wts_seq[i]) if (wts_seq[i] !== 4'(i)) bad++;
            check($sformatf("wts_seq_bad[%0d]", r), 64'(bad), 64'd0);
            check($sformatf("hold_frozen_bad[%0d]", r), 64'(frozen_bad), 64'd0);
        end

        // start held through DONE restarts the cycle after IDLE
        @(negedge clock);
        start = 1'b1;
        seen_done = 0;
        for (int n = 0; n < 1400 && seen_done == 0; n++) begin
            @(negedge clock);
            if (done) seen_done = 1;
        end
        check("held_start_done", 64'(seen_done), 64'd1);
        @(negedge clock);
        check("held_start_idle", 64'(busy), 64'd0);
        @(negedge clock);
        check("held_start_restart", 64'({busy, dp.enable_wts_rom}), 64'd3);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
